// File: rtl/cnvrow_psum_pack_pkg.sv
// Shared defaults and packed-word layout for the CNV row psum packer.
// Word layout, MSB to LSB: Dat | Num | Last.
`ifndef C_LOG_2
`define C_LOG_2(n) ($clog2(n))
`endif

package cnvrow_psum_pack_pkg;

  localparam int unsigned P_PSUM_WIDTH = 24;
  localparam int unsigned P_DATA_WIDTH = 8;
  localparam int unsigned P_LENROW     = 16;
  localparam int unsigned P_PACK       = 4;
  localparam int unsigned P_FIFO_DEPTH = 4;

  function automatic int unsigned word_width(input int unsigned dw, input int unsigned pk);
    return dw * pk + $clog2(pk + 1) + 1;
  endfunction

  localparam int unsigned P_WORD_W = word_width(P_DATA_WIDTH, P_PACK);

endpackage

// File: rtl/cnvrow_pack_fifo.sv
// First-word-fall-through FIFO for packed words, with occupancy count.
// A push while full only succeeds if a pop frees the head in the same cycle.
module cnvrow_pack_fifo
  import cnvrow_psum_pack_pkg::*;
#(
  parameter int unsigned WIDTH = P_WORD_W,
  parameter int unsigned DEPTH = P_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_dat,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_dat,
  output logic                       o_vld,
  output logic [$clog2(DEPTH+1)-1:0] o_cnt,
  output logic                       o_drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_wr;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_pop   = i_pop && !w_empty;
  assign w_wr    = i_push && (!w_full || w_pop);
  assign o_drop  = i_push && w_full && !w_pop;
  assign o_vld   = !w_empty;
  assign o_cnt   = r_cnt;
  assign o_dat   = w_empty ? '0 : r_mem[r_rd];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr)  r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + CW'(w_wr) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr] <= i_dat;
  end

endmodule

// File: rtl/cnvrow_psum_pack.sv
// Requantizes row psums, packs PACK lanes per word and queues words to the buffer.
// Build option: define PACK_RELU_EN to clamp negative lanes to zero.
module cnvrow_psum_pack
  import cnvrow_psum_pack_pkg::*;
#(
  parameter int unsigned PSUM_WIDTH = P_PSUM_WIDTH,
  parameter int unsigned DATA_WIDTH = P_DATA_WIDTH,
  parameter int unsigned LENROW     = P_LENROW,
  parameter int unsigned PACK       = P_PACK,
  parameter int unsigned FIFO_DEPTH = P_FIFO_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           CNVPCK_Vld,
  input  logic [PSUM_WIDTH-1:0]          CNVPCK_Psum,
  input  logic                           CNVPCK_FnhRow,
  input  logic [4:0]                     CFG_Shift,
  input  logic                           CFG_Clr,
  output logic                           PCKPEC_Stall,
  output logic [DATA_WIDTH*PACK-1:0]     PCKBUF_Dat,
  output logic [`C_LOG_2(PACK+1)-1:0]    PCKBUF_Num,
  output logic                           PCKBUF_Last,
  output logic                           PCKBUF_Vld,
  input  logic                           PCKBUF_Rdy,
  output logic                           PCKPEC_Err
);

  localparam int unsigned EXT_W   = PSUM_WIDTH + 1;
  localparam int unsigned NUM_W   = `C_LOG_2(PACK + 1);
  localparam int unsigned LANE_IW = (PACK > 1) ? `C_LOG_2(PACK) : 1;
  localparam int unsigned ROW_W   = `C_LOG_2(LENROW + 1);
  localparam int unsigned DAT_W   = DATA_WIDTH * PACK;
  localparam int unsigned WORD_W  = word_width(DATA_WIDTH, PACK);
  localparam int unsigned CNT_W   = `C_LOG_2(FIFO_DEPTH + 1);
  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [EXT_W-1:0] w_ext;
  logic signed [EXT_W-1:0] w_rnd;
  logic signed [EXT_W-1:0] w_sum;
  logic signed [EXT_W-1:0] w_shr;
  logic [DATA_WIDTH-1:0]   w_q;
  logic [DAT_W-1:0]        w_dat;
  logic [DAT_W-1:0]        r_dat;
  logic [LANE_IW-1:0]      r_lane_cnt;
  logic [ROW_W-1:0]        r_row_cnt;
  logic [NUM_W-1:0]        w_lane_nxt;
  logic [ROW_W-1:0]        w_row_nxt;
  logic                    w_row_end;
  logic                    w_push;
  logic                    w_last;
  logic                    w_close;
  logic [WORD_W-1:0]       w_head;
  logic [CNT_W-1:0]        w_cnt;
  logic                    w_drop;
  logic                    r_err;

  // Round half up, arithmetic shift, saturate.
  always_comb begin
    w_ext = EXT_W'($signed(CNVPCK_Psum));
    w_rnd = (CFG_Shift == 5'd0) ? '0 : (EXT_W'(1) << (CFG_Shift - 5'd1));
    w_sum = w_ext + w_rnd;
    w_shr = w_sum >>> CFG_Shift;
    if (w_shr > SAT_MAX)      w_q = SAT_MAX[DATA_WIDTH-1:0];
    else if (w_shr < SAT_MIN) w_q = SAT_MIN[DATA_WIDTH-1:0];
    else                      w_q = w_shr[DATA_WIDTH-1:0];
`ifdef PACK_RELU_EN
    if (w_q[DATA_WIDTH-1]) w_q = '0;
`endif
  end

  always_comb begin
    w_dat = r_dat;
    for (int i = 0; i < PACK; i++) begin
      if (CNVPCK_Vld && (r_lane_cnt == LANE_IW'(i))) w_dat[i*DATA_WIDTH +: DATA_WIDTH] = w_q;
    end
  end

  // A coincident FnhRow merges into the word closed by the same element.
  assign w_lane_nxt = NUM_W'(r_lane_cnt) + NUM_W'(CNVPCK_Vld);
  assign w_row_nxt  = r_row_cnt + ROW_W'(CNVPCK_Vld);
  assign w_row_end  = (w_row_nxt == ROW_W'(LENROW));
  assign w_last     = w_row_end || CNVPCK_FnhRow;
  assign w_push     = (w_lane_nxt == NUM_W'(PACK)) || w_row_end ||
                      (CNVPCK_FnhRow && ((w_lane_nxt != '0) || (w_row_nxt != '0)));
  assign w_close    = w_push || CNVPCK_FnhRow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dat      <= '0;
      r_lane_cnt <= '0;
      r_row_cnt  <= '0;
    end else begin
      if (w_close) begin
        r_dat      <= '0;
        r_lane_cnt <= '0;
      end else begin
        r_dat      <= w_dat;
        r_lane_cnt <= LANE_IW'(w_lane_nxt);
      end
      r_row_cnt <= w_last ? '0 : w_row_nxt;
    end
  end

  cnvrow_pack_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_dat  ({w_dat, w_lane_nxt, w_last}),
    .i_pop  (PCKBUF_Rdy),
    .o_dat  (w_head),
    .o_vld  (PCKBUF_Vld),
    .o_cnt  (w_cnt),
    .o_drop (w_drop)
  );

  assign {PCKBUF_Dat, PCKBUF_Num, PCKBUF_Last} = w_head;
  assign PCKPEC_Stall = (w_cnt >= CNT_W'(FIFO_DEPTH - 1));
  assign PCKPEC_Err   = r_err;

  // Sticky overflow flag; a new drop outranks a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_err <= 1'b0;
    else if (w_drop)  r_err <= 1'b1;
    else if (CFG_Clr) r_err <= 1'b0;
  end

endmodule

// File: tb/tb_cnvrow_psum_pack.sv
// Scoreboard bench for cnvrow_psum_pack: directed cases then randomized traffic.
`timescale 1ns/1ps
module tb_cnvrow_psum_pack;

  localparam int PW = 24;
  localparam int DW = 8;
  localparam int LR = 16;
  localparam int PK = 4;
  localparam int NW = 3;

  logic          clk;
  logic          rst;
  logic          CNVPCK_Vld;
  logic [PW-1:0] CNVPCK_Psum;
  logic          CNVPCK_FnhRow;
  logic [4:0]    CFG_Shift;
  logic          CFG_Clr;
  logic          PCKPEC_Stall;
  logic [DW*PK-1:0] PCKBUF_Dat;
  logic [NW-1:0] PCKBUF_Num;
  logic          PCKBUF_Last;
  logic          PCKBUF_Vld;
  logic          PCKBUF_Rdy;
  logic          PCKPEC_Err;

  cnvrow_psum_pack dut (
    .clk(clk), .rst(rst), .CNVPCK_Vld(CNVPCK_Vld), .CNVPCK_Psum(CNVPCK_Psum),
    .CNVPCK_FnhRow(CNVPCK_FnhRow), .CFG_Shift(CFG_Shift), .CFG_Clr(CFG_Clr),
    .PCKPEC_Stall(PCKPEC_Stall), .PCKBUF_Dat(PCKBUF_Dat), .PCKBUF_Num(PCKBUF_Num),
    .PCKBUF_Last(PCKBUF_Last), .PCKBUF_Vld(PCKBUF_Vld), .PCKBUF_Rdy(PCKBUF_Rdy),
    .PCKPEC_Err(PCKPEC_Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dat;
    int          num;
    bit          last;
  } exp_t;

  exp_t exp_q[$];
  int   pend[$];
  int   row_n;
  bit   model_drop;
  bit   rdy_rand;
  int   n_cmp;
  int   n_bad;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requantization straight from the arithmetic definition.
  function automatic int requant(input longint v, input int sh);
    longint r;
    r = (sh == 0) ? v : ((v + (longint'(1) << (sh - 1))) >>> sh);
    if (r > 127) r = 127;
    if (r < -128) r = -128;
`ifdef PACK_RELU_EN
    if (r < 0) r = 0;
`endif
    return int'(r);
  endfunction

  task automatic model_emit(input bit last);
    exp_t e;
    e.dat = '0;
    foreach (pend[i]) e.dat = e.dat | (32'(pend[i] & 8'hFF) << (8 * i));
    e.num  = pend.size();
    e.last = last;
    if (!model_drop) exp_q.push_back(e);
    pend.delete();
    if (last) row_n = 0;
  endtask

  task automatic model_step(input bit vld, input logic [PW-1:0] psum, input int sh, input bit fnh);
    if (vld) begin
      pend.push_back(requant(longint'($signed(psum)), sh));
      row_n++;
      if (pend.size() == PK || row_n == LR || fnh) model_emit((row_n == LR) || fnh);
    end else if (fnh) begin
      if (row_n > 0) model_emit(1'b1);
      row_n = 0;
    end
  endtask

  task automatic cyc(input bit vld, input logic [PW-1:0] psum, input bit fnh, input bit obey);
    int n;
    n = 0;
    if (obey) begin
      while (PCKPEC_Stall && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 200) chk("stall_timeout", 1, 0);
    end
    CNVPCK_Vld    = vld;
    CNVPCK_Psum   = psum;
    CNVPCK_FnhRow = fnh;
    model_step(vld, psum, int'(CFG_Shift), fnh);
    @(posedge clk); #1;
    CNVPCK_Vld    = 1'b0;
    CNVPCK_FnhRow = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    PCKBUF_Rdy = 1'b1;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic shift4_vector();
    CFG_Shift = 5'd4;
    cyc(1, 24'h000028, 0, 0);
    cyc(1, 24'h000018, 0, 0);
    cyc(1, 24'hFFFFE8, 0, 0);
    cyc(1, 24'h007FFF, 0, 0);
    chk("shift4_dat", PCKBUF_Dat, 32'h7FFF0203);
    chk("shift4_num", PCKBUF_Num, 4);
    chk("shift4_last", PCKBUF_Last, 0);
  endtask

  // Monitor: pop the scoreboard on every accepted word.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (PCKBUF_Vld && PCKBUF_Rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {PCKBUF_Dat, PCKBUF_Num, PCKBUF_Last}, -1);
        end else begin
          e = exp_q.pop_front();
          chk("word", {PCKBUF_Dat, PCKBUF_Num, PCKBUF_Last}, {e.dat, NW'(e.num), e.last});
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_rand) PCKBUF_Rdy = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [PW-1:0] ps;
    n_cmp = 0; n_bad = 0; row_n = 0; model_drop = 0; rdy_rand = 0;
    rst = 1'b1; CNVPCK_Vld = 0; CNVPCK_Psum = '0; CNVPCK_FnhRow = 0;
    CFG_Shift = '0; CFG_Clr = 0; PCKBUF_Rdy = 0;
    #2;
    chk("rst_vld", PCKBUF_Vld, 0);
    chk("rst_stall", PCKPEC_Stall, 0);
    chk("rst_err", PCKPEC_Err, 0);
    chk("rst_dat", PCKBUF_Dat, 0);
    chk("rst_num", PCKBUF_Num, 0);
    chk("rst_last", PCKBUF_Last, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Rounding and saturation, then close the row with an empty word.
    PCKBUF_Rdy = 1'b1;
    shift4_vector();
    cyc(0, '0, 1, 0);

    // Full row of identity values; next element starts at lane 0.
    CFG_Shift = 5'd0;
    for (int i = 0; i < LR; i++) cyc(1, PW'(i), 0, 0);
    chk("row_last_dat", PCKBUF_Dat, 32'h0F0E0D0C);
    chk("row_last_flag", PCKBUF_Last, 1);
    cyc(1, 24'h000055, 1, 0);
    chk("wrap_dat", PCKBUF_Dat, 32'h00000055);
    chk("wrap_num", PCKBUF_Num, 1);

    // Partial word flush, coincident close, and redundant FnhRow.
    for (int i = 0; i < 6; i++) cyc(1, PW'($urandom_range(0, 255)), 0, 0);
    cyc(0, '0, 1, 0);
    for (int i = 0; i < LR; i++) cyc(1, PW'($urandom), (i == LR - 1), 0);
    cyc(0, '0, 1, 0);
    chk("fnh_idle_no_push", PCKBUF_Vld, 0);

    // Negative lane: clamped in the ReLU build, two's complement otherwise.
    PCKBUF_Rdy = 1'b0;
    cyc(1, 24'hFFFFC0, 1, 0);
`ifdef PACK_RELU_EN
    chk("relu_lane", PCKBUF_Dat[7:0], 8'h00);
`else
    chk("signed_lane", PCKBUF_Dat[7:0], 8'hC0);
`endif
    drain();

    // Fill the FIFO, overflow, clear, then push+pop while full.
    PCKBUF_Rdy = 1'b0;
    for (int i = 0; i < LR; i++) begin
      cyc(1, PW'($urandom), 0, 0);
      if (i == 7)  chk("stall_cnt2", PCKPEC_Stall, 0);
      if (i == 11) chk("stall_cnt3", PCKPEC_Stall, 1);
    end
    chk("err_before_drop", PCKPEC_Err, 0);
    model_drop = 1;
    for (int i = 0; i < PK; i++) cyc(1, PW'($urandom), 0, 0);
    model_drop = 0;
    chk("err_on_drop", PCKPEC_Err, 1);
    CFG_Clr = 1'b1;
    @(posedge clk); #1;
    CFG_Clr = 1'b0;
    chk("err_cleared", PCKPEC_Err, 0);
    for (int i = 0; i < PK - 1; i++) cyc(1, PW'($urandom), 0, 0);
    PCKBUF_Rdy = 1'b1;
    cyc(1, PW'($urandom), 0, 0);
    chk("err_push_pop_full", PCKPEC_Err, 0);
    drain();

    // Asynchronous reset with three words queued and Err set.
    PCKBUF_Rdy = 1'b0;
    for (int i = 0; i < LR; i++) cyc(1, PW'($urandom), 0, 0);
    model_drop = 1;
    for (int i = 0; i < PK; i++) cyc(1, PW'($urandom), 0, 0);
    model_drop = 0;
    PCKBUF_Rdy = 1'b1;
    @(posedge clk); #1;
    PCKBUF_Rdy = 1'b0;
    chk("pre_rst_stall", PCKPEC_Stall, 1);
    chk("pre_rst_err", PCKPEC_Err, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_vld", PCKBUF_Vld, 0);
    chk("async_rst_stall", PCKPEC_Stall, 0);
    chk("async_rst_err", PCKPEC_Err, 0);
    exp_q.delete(); pend.delete(); row_n = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    PCKBUF_Rdy = 1'b1;
    shift4_vector();
    cyc(0, '0, 1, 0);

    // Randomized traffic honouring Stall, with random consumer back-pressure.
    rdy_rand = 1;
    for (int k = 0; k < 600; k++) begin
      if (row_n == 0 && $urandom_range(0, 3) == 0) CFG_Shift = 5'($urandom_range(0, 12));
      ps = ($urandom_range(0, 1) == 1) ? PW'($urandom) : PW'($urandom_range(0, 4095) - 2048);
      cyc($urandom_range(0, 3) != 0, ps, $urandom_range(0, 19) == 0, 1);
    end
    cyc(0, '0, 1, 1);
    rdy_rand = 0;
    @(posedge clk); #1;
    drain();
    @(posedge clk); #1;
    chk("final_err", PCKPEC_Err, 0);
    chk("final_vld", PCKBUF_Vld, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
